mem_port_arbiter: RTL

//  Shares one single-ported unified memory between the fetch stage (instruction reads) and the memory stage (loads/stores).

---
 rtl/riscv_pp_pkg.sv | 21 ++
 rtl/arb_sat_counter.sv | 24 ++
 rtl/mem_port_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/riscv_pp_pkg.sv
// Shared types and defaults for the pipeline memory-port arbiter.
package riscv_pp_pkg;

  localparam int XLEN          = 32;
  localparam int IF_STARVE_MAX = 4;
  localparam int CNT_W         = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    ACK  = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2
  } arb_owner_t;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear; stops counting once MAX is reached.
module arb_sat_counter #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  // Clear has priority over increment; increment stops at MAX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and the
// data (load/store) stage. One outstanding access: IDLE -> REQ -> RESP -> ACK.
// Data normally wins; fetch wins once after IF_STARVE_MAX consecutive losses.
// Optional: define ARB_PERF_CNT_EN to add conflict/stall performance counters.
module mem_port_arbiter #(
  parameter int XLEN          = riscv_pp_pkg::XLEN,
  parameter int IF_STARVE_MAX = riscv_pp_pkg::IF_STARVE_MAX
`ifdef ARB_PERF_CNT_EN
  ,
  parameter int CNT_W         = riscv_pp_pkg::CNT_W
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req_i,
  input  logic [XLEN-1:0] if_addr_i,
  output logic            if_ack_o,
  output logic [XLEN-1:0] if_rdata_o,
  input  logic            dm_req_i,
  input  logic            dm_we_i,
  input  logic [XLEN-1:0] dm_addr_i,
  input  logic [XLEN-1:0] dm_wdata_i,
  input  logic [3:0]      dm_be_i,
  output logic            dm_ack_o,
  output logic [XLEN-1:0] dm_rdata_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic [3:0]      mem_be_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            stall_f_o,
  output logic            stall_m_o
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_conflict_o,
  output logic [CNT_W-1:0] perf_stall_o
`endif
);

  import riscv_pp_pkg::*;

  localparam int               STARVE_W   = $clog2(IF_STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(IF_STARVE_MAX);

  arb_state_t          state;
  arb_owner_t          owner;
  logic [STARVE_W-1:0] starve_cnt;
  logic                grant_i;
  logic                grant_d;
  logic                both_req;

  assign stall_f_o = if_req_i & ~if_ack_o;
  assign stall_m_o = dm_req_i & ~dm_ack_o;
  assign both_req  = if_req_i & dm_req_i;

  // Arbitration decision, only meaningful while idle.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE) begin
      grant_i = if_req_i & (~dm_req_i | (starve_cnt == STARVE_MAX));
      grant_d = dm_req_i & ~grant_i;
    end
  end

  // Counts consecutive arbitrations fetch lost to data; reset by any fetch grant.
  arb_sat_counter #(
    .WIDTH (STARVE_W),
    .MAX   (STARVE_MAX)
  ) u_starve_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (grant_d & if_req_i),
    .clear (grant_i),
    .count (starve_cnt)
  );

  // Access sequencer: latch the winner, hold request until granted, capture response, ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= NONE;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_be_o    <= 4'h0;
      if_ack_o    <= 1'b0;
      dm_ack_o    <= 1'b0;
      if_rdata_o  <= '0;
      dm_rdata_o  <= '0;
    end else begin
      if_ack_o <= 1'b0;
      dm_ack_o <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_i) begin
            owner       <= OWN_I;
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= if_addr_i;
            mem_wdata_o <= '0;
            mem_be_o    <= 4'hF;
            state       <= REQ;
          end else if (grant_d) begin
            owner       <= OWN_D;
            mem_req_o   <= 1'b1;
            mem_we_o    <= dm_we_i;
            mem_addr_o  <= dm_addr_i;
            mem_wdata_o <= dm_wdata_i;
            mem_be_o    <= dm_be_i;
            state       <= REQ;
          end
        end
        REQ: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            state     <= RESP;
          end
        end
        RESP: begin
          if (mem_rvalid_i) begin
            if (owner == OWN_I) begin
              if_rdata_o <= mem_rdata_i;
              if_ack_o   <= 1'b1;
            end else begin
              dm_rdata_o <= mem_rdata_i;
              dm_ack_o   <= 1'b1;
            end
            state <= ACK;
          end
        end
        ACK: begin
          owner <= NONE;
          state <= IDLE;
        end
        default: begin
          owner <= NONE;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  // Cycles spent idle with both stages requesting.
  arb_sat_counter #(
    .WIDTH (CNT_W)
  ) u_perf_conflict (
    .clk   (clk),
    .reset (reset),
    .inc   ((state == IDLE) & both_req),
    .clear (1'b0),
    .count (perf_conflict_o)
  );

  // Cycles where either pipeline stage is stalled on memory.
  arb_sat_counter #(
    .WIDTH (CNT_W)
  ) u_perf_stall (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_f_o | stall_m_o),
    .clear (1'b0),
    .count (perf_stall_o)
  );
`else
  logic unused_both_req;
  assign unused_both_req = both_req;
`endif

endmodule
